// File: rtl/eth_rx_frame_parser.sv
// Receive-side Ethernet framer: finds preamble/SFD, filters on destination MAC
// and EtherType, strips the 4-byte FCS and streams the IP datagram on isIp/dataout.
module eth_rx_frame_parser #(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [15:0] ETHERTYPE    = 16'h0800
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        isIp,
  output logic [7:0]  dataout,
  output logic [47:0] src_mac,
  output logic        is_bcast,
  output logic        frame_done,
  output logic        frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DST,
    S_SRC,
    S_ETYPE,
    S_PAYLOAD,
    S_DROP
  } state_t;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  state_t      state_q, state_d;
  logic [2:0]  pre_cnt_q, pre_cnt_d;
  logic [2:0]  fld_cnt_q, fld_cnt_d;
  logic [2:0]  pay_cnt_q, pay_cnt_d;
  logic        dst_hit_q, dst_hit_d;
  logic        dst_bc_q, dst_bc_d;
  logic        bcast_q, bcast_d;
  logic [47:0] src_shadow_q, src_shadow_d;
  logic [7:0]  etype_hi_q, etype_hi_d;
  logic [31:0] dly_q, dly_d;

  logic        isip_d;
  logic [7:0]  dataout_d;
  logic [47:0] src_mac_d;
  logic        is_bcast_d;
  logic        frame_done_d;
  logic        frame_err_d;

  logic        byte_hit;
  logic        byte_bc;

  function automatic logic [7:0] mac_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return MAC_ADDR[47:40];
      3'd1:    return MAC_ADDR[39:32];
      3'd2:    return MAC_ADDR[31:24];
      3'd3:    return MAC_ADDR[23:16];
      3'd4:    return MAC_ADDR[15:8];
      default: return MAC_ADDR[7:0];
    endcase
  endfunction

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Running match of the destination address, byte by byte as it arrives
  assign byte_hit = dst_hit_q && (rx_data == mac_byte(fld_cnt_q));
  assign byte_bc  = dst_bc_q && (rx_data == 8'hFF);

  always_comb begin
    state_d      = state_q;
    pre_cnt_d    = pre_cnt_q;
    fld_cnt_d    = fld_cnt_q;
    pay_cnt_d    = pay_cnt_q;
    dst_hit_d    = dst_hit_q;
    dst_bc_d     = dst_bc_q;
    bcast_d      = bcast_q;
    src_shadow_d = src_shadow_q;
    etype_hi_d   = etype_hi_q;
    dly_d        = dly_q;
    isip_d       = 1'b0;
    dataout_d    = '0;
    src_mac_d    = src_mac;
    is_bcast_d   = is_bcast;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_dv) begin
          fld_cnt_d = '0;
          dst_hit_d = 1'b1;
          dst_bc_d  = 1'b1;
          if (rx_data == PRE_BYTE) begin
            state_d   = S_PREAMBLE;
            pre_cnt_d = 3'd1;
          end else if (rx_data == SFD_BYTE) begin
            state_d = S_DST;
          end else begin
            state_d     = S_DROP;
            frame_err_d = 1'b1;
          end
        end
      end

      S_PREAMBLE: begin
        if (!rx_dv) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (rx_data == PRE_BYTE) begin
          if (pre_cnt_q == 3'd7) begin
            state_d     = S_DROP;
            frame_err_d = 1'b1;
          end else begin
            pre_cnt_d = sat_inc(pre_cnt_q);
          end
        end else if (rx_data == SFD_BYTE) begin
          state_d = S_DST;
        end else begin
          state_d     = S_DROP;
          frame_err_d = 1'b1;
        end
      end

      S_DST: begin
        if (!rx_dv) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (fld_cnt_q == 3'd5) begin
          fld_cnt_d = '0;
          if (ACCEPT_BCAST && byte_bc) begin
            state_d = S_SRC;
            bcast_d = 1'b1;
          end else if (byte_hit) begin
            state_d = S_SRC;
            bcast_d = 1'b0;
          end else begin
            state_d = S_DROP;
          end
        end else begin
          fld_cnt_d = sat_inc(fld_cnt_q);
          dst_hit_d = byte_hit;
          dst_bc_d  = byte_bc;
        end
      end

      S_SRC: begin
        if (!rx_dv) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          src_shadow_d = {src_shadow_q[39:0], rx_data};
          if (fld_cnt_q == 3'd5) begin
            fld_cnt_d = '0;
            state_d   = S_ETYPE;
          end else begin
            fld_cnt_d = sat_inc(fld_cnt_q);
          end
        end
      end

      S_ETYPE: begin
        if (!rx_dv) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else if (fld_cnt_q == 3'd0) begin
          etype_hi_d = rx_data;
          fld_cnt_d  = 3'd1;
        end else if ({etype_hi_q, rx_data} == ETHERTYPE) begin
          state_d    = S_PAYLOAD;
          src_mac_d  = src_shadow_q;
          is_bcast_d = bcast_q;
          pay_cnt_d  = '0;
          dly_d      = '0;
        end else begin
          state_d = S_DROP;
        end
      end

      // Oldest byte leaves the delay line only once four newer bytes exist,
      // so the trailing FCS is never emitted.
      S_PAYLOAD: begin
        if (!rx_dv) begin
          state_d      = S_IDLE;
          frame_done_d = isIp;
        end else begin
          dly_d = {dly_q[23:0], rx_data};
          if (pay_cnt_q >= 3'd4) begin
            isip_d    = 1'b1;
            dataout_d = dly_q[31:24];
          end else begin
            pay_cnt_d = sat_inc(pay_cnt_q);
          end
        end
      end

      S_DROP: begin
        if (!rx_dv) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pre_cnt_q    <= '0;
      fld_cnt_q    <= '0;
      pay_cnt_q    <= '0;
      dst_hit_q    <= 1'b0;
      dst_bc_q     <= 1'b0;
      bcast_q      <= 1'b0;
      src_shadow_q <= '0;
      etype_hi_q   <= '0;
      dly_q        <= '0;
      isIp         <= 1'b0;
      dataout      <= '0;
      src_mac      <= '0;
      is_bcast     <= 1'b0;
      frame_done   <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pre_cnt_q    <= pre_cnt_d;
      fld_cnt_q    <= fld_cnt_d;
      pay_cnt_q    <= pay_cnt_d;
      dst_hit_q    <= dst_hit_d;
      dst_bc_q     <= dst_bc_d;
      bcast_q      <= bcast_d;
      src_shadow_q <= src_shadow_d;
      etype_hi_q   <= etype_hi_d;
      dly_q        <= dly_d;
      isIp         <= isip_d;
      dataout      <= dataout_d;
      src_mac      <= src_mac_d;
      is_bcast     <= is_bcast_d;
      frame_done   <= frame_done_d;
      frame_err    <= frame_err_d;
    end
  end

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Self-checking bench for eth_rx_frame_parser: directed and random frames
// compared against a frame-level reference model.
module tb_eth_rx_frame_parser;

  localparam logic [47:0] MAC   = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST = 48'hFF_FF_FF_FF_FF_FF;
  localparam logic [15:0] ET_IP = 16'h0800;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        isIp;
  logic [7:0]  dataout;
  logic [47:0] src_mac;
  logic        is_bcast;
  logic        frame_done;
  logic        frame_err;

  always #5 clock = ~clock;

  eth_rx_frame_parser #(
    .MAC_ADDR    (MAC),
    .ACCEPT_BCAST(1'b1),
    .ETHERTYPE   (ET_IP)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .rx_dv     (rx_dv),
    .rx_data   (rx_data),
    .isIp      (isIp),
    .dataout   (dataout),
    .src_mac   (src_mac),
    .is_bcast  (is_bcast),
    .frame_done(frame_done),
    .frame_err (frame_err)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // frame under test and model expectations
  logic [7:0]  fr[$];
  logic [7:0]  exp_q[$];
  int          exp_first, exp_err, exp_err_n, exp_done;
  logic [47:0] exp_src = '0;
  logic        exp_bcast = 1'b0;

  // monitor observations, indexed by tick within the current frame
  logic [7:0]  obs_q[$];
  int          mon_n, obs_first, obs_last, done_cnt, done_n, err_cnt, err_n, zero_viol;

  task automatic mon_clear();
    obs_q.delete();
    mon_n = 0; obs_first = -1; obs_last = -1;
    done_cnt = 0; done_n = -1; err_cnt = 0; err_n = -1; zero_viol = 0;
  endtask

  task automatic tick();
    @(negedge clock);
    if (isIp) begin
      obs_q.push_back(dataout);
      if (obs_first < 0) obs_first = mon_n;
      obs_last = mon_n;
    end else if (dataout != 8'h00) begin
      zero_viol++;
    end
    if (frame_done) begin
      done_cnt++;
      if (done_n < 0) done_n = mon_n;
    end
    if (frame_err) begin
      err_cnt++;
      if (err_n < 0) err_n = mon_n;
    end
    mon_n++;
  endtask

  task automatic build(input int pre_n, input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et, input int pay_n);
    fr.delete();
    repeat (pre_n) fr.push_back(8'h55);
    fr.push_back(8'hD5);
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
    fr.push_back(et[15:8]);
    fr.push_back(et[7:0]);
    for (int i = 0; i < pay_n; i++) fr.push_back(8'($urandom_range(0, 255)));
  endtask

  // Frame-level reference: walk the byte list with the framing rules.
  task automatic model();
    int n55, h, len, plen;
    logic [47:0] dst, src;
    exp_q.delete();
    exp_err = 0; exp_err_n = -1; exp_done = 0; exp_first = -1;
    len = fr.size();
    n55 = 0;
    while (n55 < len && fr[n55] == 8'h55) n55++;
    if (n55 >= 8) begin exp_err = 1; exp_err_n = 7; return; end
    if (n55 == len) begin exp_err = 1; exp_err_n = len; return; end
    if (fr[n55] != 8'hD5) begin exp_err = 1; exp_err_n = n55; return; end
    h = n55 + 1;
    if (len < h + 6) begin exp_err = 1; exp_err_n = len; return; end
    dst = '0;
    for (int i = 0; i < 6; i++) dst = {dst[39:0], fr[h+i]};
    if (!(dst == MAC || dst == BCAST)) return;
    if (len < h + 14) begin exp_err = 1; exp_err_n = len; return; end
    if ({fr[h+12], fr[h+13]} != ET_IP) return;
    src = '0;
    for (int i = 0; i < 6; i++) src = {src[39:0], fr[h+6+i]};
    exp_src   = src;
    exp_bcast = (dst == BCAST);
    plen = len - h - 14;
    if (plen >= 5) begin
      exp_done  = 1;
      exp_first = h + 14 + 4;
      for (int i = 0; i < plen - 4; i++) exp_q.push_back(fr[h+14+i]);
    end
  endtask

  task automatic run_frame(input string name, input int gap);
    int len;
    model();
    mon_clear();
    len = fr.size();
    foreach (fr[i]) begin
      rx_dv = 1'b1; rx_data = fr[i];
      tick();
    end
    for (int g = 0; g < gap; g++) begin
      rx_dv = 1'b0; rx_data = 8'h00;
      tick();
    end
    check_eq({name, ".ip_len"}, 64'(obs_q.size()), 64'(exp_q.size()));
    if (obs_q.size() == exp_q.size())
      foreach (exp_q[i]) check_eq({name, ".ip_byte"}, 64'(obs_q[i]), 64'(exp_q[i]));
    check_eq({name, ".ip_rise"}, 64'(obs_first), 64'(exp_first));
    check_eq({name, ".ip_last"}, 64'(obs_last), 64'((exp_q.size() > 0) ? len - 1 : -1));
    check_eq({name, ".done_cnt"}, 64'(done_cnt), 64'(exp_done));
    check_eq({name, ".done_at"}, 64'(done_n), 64'(exp_done ? len : -1));
    check_eq({name, ".err_cnt"}, 64'(err_cnt), 64'(exp_err));
    check_eq({name, ".err_at"}, 64'(err_n), 64'(exp_err_n));
    check_eq({name, ".dout_zero"}, 64'(zero_viol), 64'd0);
    check_eq({name, ".src_mac"}, 64'(src_mac), 64'(exp_src));
    check_eq({name, ".is_bcast"}, 64'(is_bcast), 64'(exp_bcast));
  endtask

  task automatic reset_mid_frame();
    build(7, MAC, 48'h11_22_33_44_55_66, ET_IP, 20);
    fr[34] = 8'h3C;
    model();
    mon_clear();
    for (int i = 0; i <= 32; i++) begin
      rx_dv = 1'b1; rx_data = fr[i];
      tick();
    end
    check_eq("rst.ip_before", 64'(isIp), 64'd1);
    #1 reset = 1'b1;
    #1;
    check_eq("rst.ip_async", 64'(isIp), 64'd0);
    check_eq("rst.dout_async", 64'(dataout), 64'd0);
    check_eq("rst.src_async", 64'(src_mac), 64'd0);
    exp_src = '0;
    exp_bcast = 1'b0;
    rx_dv = 1'b1; rx_data = fr[33];
    tick();
    reset = 1'b0;
    mon_clear();
    for (int i = 34; i < fr.size(); i++) begin
      rx_dv = 1'b1; rx_data = fr[i];
      tick();
    end
    rx_dv = 1'b0; rx_data = 8'h00;
    tick();
    check_eq("rst.err_cnt", 64'(err_cnt), 64'd1);
    check_eq("rst.err_at", 64'(err_n), 64'd0);
    check_eq("rst.ip_len", 64'(obs_q.size()), 64'd0);
    check_eq("rst.done_cnt", 64'(done_cnt), 64'd0);
    check_eq("rst.src_mac", 64'(src_mac), 64'(exp_src));
  endtask

  initial begin
    logic [63:0] r64;
    logic [47:0] dst, src;
    logic [15:0] et;
    int kind, pre, pay, idx;

    #2 reset = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("reset.isIp", 64'(isIp), 64'd0);
    check_eq("reset.dataout", 64'(dataout), 64'd0);
    check_eq("reset.src_mac", 64'(src_mac), 64'd0);
    check_eq("reset.is_bcast", 64'(is_bcast), 64'd0);
    check_eq("reset.frame_done", 64'(frame_done), 64'd0);
    check_eq("reset.frame_err", 64'(frame_err), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    build(7, MAC, 48'h0A_0B_0C_0D_0E_0F, ET_IP, 24);
    fr[22] = 8'h45;
    fr[23] = 8'h00;
    run_frame("ip20", 1);
    check_eq("ip20.src_const", 64'(src_mac), 64'h0A0B0C0D0E0F);

    build(7, MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0806, 24);
    run_frame("arp", 1);
    build(7, 48'h02_00_00_00_00_02, 48'h0A_0B_0C_0D_0E_01, ET_IP, 24);
    run_frame("wrong_dst", 1);
    build(7, BCAST, 48'h0A_0B_0C_0D_0E_02, ET_IP, 12);
    run_frame("bcast", 1);
    check_eq("bcast.flag_const", 64'(is_bcast), 64'd1);

    fr.delete();
    fr.push_back(8'h55); fr.push_back(8'h55); fr.push_back(8'hAA);
    repeat (5) fr.push_back(8'($urandom_range(0, 255)));
    run_frame("bad_pre", 1);
    build(3, MAC, 48'h0A_0B_0C_0D_0E_03, ET_IP, 10);
    run_frame("after_bad", 2);

    build(7, MAC, 48'h0A_0B_0C_0D_0E_04, ET_IP, 0);
    while (fr.size() > 11) void'(fr.pop_back());
    run_frame("trunc_dst", 1);
    build(7, MAC, 48'h0A_0B_0C_0D_0E_05, ET_IP, 4);
    run_frame("fcs_only", 1);
    build(7, MAC, 48'h0A_0B_0C_0D_0E_06, ET_IP, 5);
    run_frame("pay5", 1);
    build(8, MAC, 48'h0A_0B_0C_0D_0E_07, ET_IP, 8);
    run_frame("long_pre", 1);
    build(0, MAC, 48'h0A_0B_0C_0D_0E_08, ET_IP, 8);
    run_frame("no_pre", 1);

    reset_mid_frame();
    build(7, MAC, 48'h0A_0B_0C_0D_0E_09, ET_IP, 15);
    run_frame("post_rst", 1);

    for (int f = 0; f < 150; f++) begin
      kind = $urandom_range(0, 7);
      pre  = $urandom_range(0, 7);
      pay  = $urandom_range(0, 24);
      r64  = {$urandom(), $urandom()};
      src  = r64[47:0];
      dst  = (kind == 1) ? BCAST : MAC;
      et   = ET_IP;
      if (kind == 3) dst = MAC ^ (48'h1 << (8 * $urandom_range(0, 5)));
      if (kind == 4) et = 16'h0806;
      if (kind == 7) pre = 8 + $urandom_range(0, 2);
      build(pre, dst, src, et, pay);
      if (kind == 5) begin
        idx = $urandom_range(0, pre);
        fr[idx] = 8'($urandom_range(0, 8'h50));
      end
      if (kind == 6) begin
        idx = $urandom_range(1, pre + 14);
        while (fr.size() > idx) void'(fr.pop_back());
      end
      run_frame("rand", $urandom_range(1, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/eth_rx_frame_parser.md
Name: eth_rx_frame_parser

Overview:
Receive-side Ethernet framer directly upstream of the IP header checker. Takes the raw byte stream from the PHY/MAC adapter and finds preamble/SFD. Filters on destination MAC and EtherType 0x0800, then strips the 4-byte FCS. Delivers the IP datagram bytes as a contiguous, one-byte-per-clock stream, framed by a level strobe (isIp) that the IP header checker consumes directly.

Parameters:
MAC_ADDR, 48'h02_00_00_00_00_01, station address accepted as destination
ACCEPT_BCAST, 1, 1 = also accept FF:FF:FF:FF:FF:FF
ETHERTYPE, 16'h0800, EtherType forwarded on isIp

Ports:
clock  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-high reset
rx_dv  in  1  frame-valid; high for the whole frame, one byte per clock, low for >=1 clock between frames
rx_data  in  8  received byte, valid when rx_dv=1
isIp  out  1  high while dataout carries IP datagram bytes (contiguous run, one byte/clock)
dataout  out  8  datagram byte aligned with isIp
src_mac  out  48  source MAC of current frame, stable from isIp rise until next frame's SRC field
is_bcast  out  1  current frame was broadcast-addressed, same validity as src_mac
frame_done  out  1  1-clock pulse after an accepted IP frame ends
frame_err  out  1  1-clock pulse on malformed frame (bad preamble/SFD, rx_dv drop before EtherType complete)

Behaviour:
- Reset (async): state=IDLE; isIp, dataout, src_mac, is_bcast, frame_done, frame_err all 0; delay line and counters cleared.
- FSM, posedge clock:
  - IDLE: on rx_dv=1: byte 0x55 -> PREAMBLE; byte 0xD5 -> DST; anything else -> DROP with frame_err pulse.
  - PREAMBLE: 0x55 stays, counting up to 7; 0xD5 -> DST; any other byte or >7 x 0x55 -> DROP plus frame_err.
  - DST: 6 bytes, MSB first, compared on the fly. At the 6th byte, match MAC_ADDR -> SRC. All-ones with ACCEPT_BCAST=1 -> SRC with is_bcast=1. Otherwise DROP, no error.
  - SRC: 6 bytes shifted into a shadow register. Copied to src_mac at the last ETYPE byte, only if the frame is accepted.
  - ETYPE: 2 bytes. == ETHERTYPE -> PAYLOAD. Else DROP, no error.
  - PAYLOAD: bytes enter a 4-deep byte delay line.
  - DROP: ignore bytes until rx_dv=0.
  - rx_dv=0 in any non-IDLE state -> IDLE.
  - rx_dv falling in PREAMBLE/DST/SRC/ETYPE -> frame_err pulse.
- FCS stripping:
  - A payload byte is emitted only once 4 newer bytes have been received.
  - Payload byte k appears on dataout/isIp one clock after byte k+4 is sampled.
  - The 4 bytes left in the delay line when rx_dv falls are the FCS and are discarded. No FCS check is performed.
- isIp:
  - Rises the clock after the 5th payload byte is sampled.
  - Falls the clock after rx_dv is sampled low.
  - Never high for two frames without a low cycle in between; the downstream counter resets on isIp low.
- frame_done:
  - Pulses in the same clock isIp falls, for frames that reached PAYLOAD with at least 5 payload bytes.
  - Frames with 1–4 payload bytes: isIp never asserts, no frame_done, no frame_err.
- dataout = 0 whenever isIp = 0.
- Counters: preamble counter 3 bit, field counter 3 bit. They saturate and never wrap into a false match.
- rx_dv high in IDLE on the cycle after a frame end starts a new frame normally. The output of the old frame (isIp fall) and the parsing of the new frame proceed independently.
- Reset mid-frame: all outputs drop asynchronously. Parsing resumes from IDLE, so the rest of that frame is treated as a new frame. Its non-0x55/0xD5 bytes yield frame_err and DROP.

Test Plan:
- 7x55, D5, dst=MAC_ADDR, src=0A:0B:0C:0D:0E:0F, 08 00, 20-byte IP header 45 00 .., 4 FCS -> isIp high exactly 20 clocks, starting 5 clocks after the first payload byte; dataout = the 20 header bytes in order; src_mac=0x0A0B0C0D0E0F; frame_done pulse; frame_err=0.
- Same frame with EtherType 08 06 (ARP) -> isIp never asserts, no frame_done, no frame_err.
- Dst 02:00:00:00:00:02 -> dropped silently. Dst FF..FF with ACCEPT_BCAST=1 -> forwarded with is_bcast=1.
- Preamble 55 55 AA -> frame_err pulse one clock later, DROP until rx_dv low. Next good frame after a 1-clock gap is forwarded intact.
- rx_dv falls after 3 dst bytes -> frame_err pulse. Payload of exactly 4 bytes (FCS only) -> no isIp, no frame_done.
- reset asserted for 1 clock mid-payload -> isIp=0 and dataout=0 immediately (asynchronous). The remaining bytes of that frame produce frame_err. The following clean frame is parsed normally.
